// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus initiator that copies a block of 32-bit words from a source word
//   address to a destination word address over the data-memory interface.
//   Each word costs three cycles: READ (address out, read strobe), WAIT
//   (read data returns and is captured), WRITE (write strobe, data out).
//   Address arithmetic wraps modulo 2^ADDR_WIDTH. Copies always run forward.
//
// Optional feature macro: MEM_COPY_CHECKSUM_EN
//   When defined, adds a 32-bit running sum of every word written.
//
// Ports
//   clk, rst          system clock (rising edge), async active-high reset
//   start             single-cycle request, honoured only in IDLE
//   src_addr/dst_addr first source / destination word address
//   length            number of words to copy
//   busy              high from the cycle after accept through DONE
//   done              one-cycle completion pulse
//   words_done        words written in the current or last transfer
//   mem_addr/mem_wdata/mem_write_en/mem_read  memory request signals
//   mem_rdata         read data, valid the cycle after mem_read
//   checksum          (MEM_COPY_CHECKSUM_EN only) sum of written words
//
// state   | meaning
// S_IDLE  | waiting for start, no strobes
// S_READ  | mem_read high, address = src + idx
// S_WAIT  | read data returning, captured at end of cycle
// S_WRITE | mem_write_en high, address = dst + idx
// S_DONE  | done pulse, busy still high

module mem_copy_engine #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] words_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_write_en,
  output logic                  mem_read,
  input  logic [31:0]           mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           data_q;

  assign idx_next = idx + 1'b1;
  assign rd_addr  = src_q + idx;
  assign wr_addr  = dst_q + idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset removes them in the same instant, with no pending edge.
  always_comb begin
    next_state   = state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_read     = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state)
      S_IDLE: begin
        if (start) next_state = (length != '0) ? S_READ : S_DONE;
      end
      S_READ: begin
        busy       = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = rd_addr;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        busy       = 1'b1;
        mem_addr   = rd_addr;
        next_state = S_WRITE;
      end
      S_WRITE: begin
        busy         = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = wr_addr;
        mem_wdata    = data_q;
        next_state   = (idx_next == len_q) ? S_DONE : S_READ;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx        <= '0;
      words_done <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            len_q      <= length;
            idx        <= '0;
            words_done <= '0;
          end
        end
        S_WAIT:  data_q <= mem_rdata;
        S_WRITE: begin
          idx        <= idx_next;
          words_done <= words_done + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (state == S_WRITE)       checksum <= checksum + data_q;
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
//   Directed bench for mem_copy_engine with a behavioural memory that
//   returns read data one cycle after the read strobe.

`timescale 1ns/1ps

module tb_mem_copy_engine;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr, length;
  logic          busy, done;
  logic [AW-1:0] words_done, mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_write_en, mem_read;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0]   checksum;
  logic [31:0]   cs_at_done;
`endif

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  logic [31:0]   mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int done_cnt   = 0;
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .words_done(words_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
`ifdef MEM_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always @(posedge clk) begin
    if (mem_write_en)  mem[mem_addr] <= mem_wdata;
    else if (pre_we)   mem[pre_addr] <= pre_data;
    if (mem_read)      mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    checks++;
    assert (!(mem_read && mem_write_en)) else begin
      failures++;
      $error("FAIL strobe_overlap obs=%b%b exp=not both", mem_read, mem_write_en);
    end
    if (mem_read || mem_write_en) strobe_cnt++;
    if (mem_read) rd_q.push_back(mem_addr);
    if (mem_write_en) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (done) begin
      done_cnt++;
`ifdef MEM_COPY_CHECKSUM_EN
      cs_at_done = checksum;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Accepts start on the next rising edge and returns the cycle number
  // (1 = cycle right after the accept edge) in which done is seen.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] n, output int cyc);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (done) begin cyc = k; break; end
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state and idle quiet period
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_we", 32'(mem_write_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_words_done", 32'(words_done), 0);
    strobe_cnt = 0;
    repeat (20) @(negedge clk);
    chk("idle_strobes", strobe_cnt, 0);

    // Basic copy of four words
    preload(10'h010, 32'h11111111);
    preload(10'h011, 32'h22222222);
    preload(10'h012, 32'h33333333);
    preload(10'h013, 32'h44444444);
    run_copy(10'h010, 10'h100, 10'd4, cyc);
    chk("basic_done_cycle", cyc, 13);
    chk("basic_busy_at_done", 32'(busy), 1);
    chk("basic_words_done", 32'(words_done), 4);
    @(negedge clk);
    chk("basic_busy_after", 32'(busy), 0);
    chk("basic_done_after", 32'(done), 0);
    chk("basic_words_hold", 32'(words_done), 4);
    chk("basic_mem100", mem[10'h100], 32'h11111111);
    chk("basic_mem101", mem[10'h101], 32'h22222222);
    chk("basic_mem102", mem[10'h102], 32'h33333333);
    chk("basic_mem103", mem[10'h103], 32'h44444444);

    // Zero length
    strobe_cnt = 0;
    run_copy(10'h005, 10'h006, 10'd0, cyc);
    chk("zero_done_cycle", cyc, 1);
    chk("zero_words_done", 32'(words_done), 0);
    repeat (2) @(negedge clk);
    chk("zero_strobes", strobe_cnt, 0);

    // Wrap-around of the source address
    preload(10'h3FE, 32'hA0A0A0A0);
    preload(10'h3FF, 32'hB1B1B1B1);
    preload(10'h000, 32'hC2C2C2C2);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    run_copy(10'h3FE, 10'h001, 10'd3, cyc);
    chk("wrap_done_cycle", cyc, 10);
    chk("wrap_nreads", rd_q.size(), 3);
    chk("wrap_nwrites", wa_q.size(), 3);
    if (rd_q.size() == 3 && wa_q.size() == 3) begin
      chk("wrap_rd0", 32'(rd_q[0]), 32'h3FE);
      chk("wrap_rd1", 32'(rd_q[1]), 32'h3FF);
      chk("wrap_rd2", 32'(rd_q[2]), 32'h000);
      chk("wrap_wa0", 32'(wa_q[0]), 32'h001);
      chk("wrap_wa1", 32'(wa_q[1]), 32'h002);
      chk("wrap_wa2", 32'(wa_q[2]), 32'h003);
      chk("wrap_wd0", wd_q[0], 32'hA0A0A0A0);
      chk("wrap_wd1", wd_q[1], 32'hB1B1B1B1);
      chk("wrap_wd2", wd_q[2], 32'hC2C2C2C2);
    end

    // Start while busy is ignored
    preload(10'h020, 32'hDEAD0001);
    preload(10'h021, 32'hDEAD0002);
    preload(10'h022, 32'hDEAD0003);
    preload(10'h023, 32'hDEAD0004);
    @(negedge clk);
    src_addr = 10'h020; dst_addr = 10'h140; length = 10'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 5) begin
        src_addr = 10'h030; dst_addr = 10'h200; length = 10'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin cyc = k; break; end
    end
    chk("busy_start_done_cycle", cyc, 13);
    chk("busy_start_words", 32'(words_done), 4);
    strobe_cnt = 0;
    repeat (6) @(negedge clk);
    chk("busy_start_no_restart", strobe_cnt, 0);
    chk("busy_start_mem140", mem[10'h140], 32'hDEAD0001);
    chk("busy_start_mem143", mem[10'h143], 32'hDEAD0004);

    // Reset during a WRITE cycle
    run_copy(10'h010, 10'h180, 10'd0, cyc);  // settle to IDLE first
    @(negedge clk);
    src_addr = 10'h010; dst_addr = 10'h180; length = 10'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_write_en) begin cyc = k; break; end
    end
    chk("rstmid_write_seen", cyc, 3);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_we_drop", 32'(mem_write_en), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_words", 32'(words_done), 0);
    @(negedge clk) rst = 1'b0;
    strobe_cnt = 0; done_cnt = 0;
    repeat (15) @(negedge clk);
    chk("rstmid_no_strobes", strobe_cnt, 0);
    chk("rstmid_no_done", done_cnt, 0);

`ifdef MEM_COPY_CHECKSUM_EN
    preload(10'h050, 32'hFFFFFFFF);
    preload(10'h051, 32'h00000002);
    run_copy(10'h050, 10'h060, 10'd2, cyc);
    chk("cs_done_cycle", cyc, 7);
    @(negedge clk);
    chk("cs_at_done", cs_at_done, 32'h00000001);
    chk("cs_hold", checksum, 32'h00000001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator that drives the data-memory interface (addr / write data / write enable / read enable) to copy a block of 32-bit words from a source word address to a destination word address.
- Sits beside the CPU datapath and targets the memory unit. The memory unit returns read data one cycle after the read address, and it decodes the memory-mapped I/O addresses itself.
- The engine treats every address uniformly. A destination range that covers the output-port address therefore drives the output port.

Parameters:
- ADDR_WIDTH, 10, width of word addresses and of the length field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- src_addr  input  ADDR_WIDTH  first source word address, latched on accepted start.
- dst_addr  input  ADDR_WIDTH  first destination word address, latched on accepted start.
- length  input  ADDR_WIDTH  number of words to copy, latched on accepted start.
- busy  output  1  high from the cycle after accepted start through the DONE state.
- done  output  1  one-cycle pulse when the transfer completes.
- words_done  output  ADDR_WIDTH  count of words written in the current or last transfer.
- mem_addr  output  ADDR_WIDTH  address to the memory unit.
- mem_wdata  output  32  write data to the memory unit.
- mem_write_en  output  1  write strobe to the memory unit.
- mem_read  output  1  read enable to the memory unit.
- mem_rdata  input  32  read data; valid in the cycle after mem_read is asserted.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - busy, done, mem_write_en, mem_read = 0.
  - mem_addr, mem_wdata, words_done = 0.
  - All internal registers = 0.
  - A reset mid-transfer abandons the transfer. No further memory strobes are issued.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - All strobes are 0.
  - On start=1: latch src_addr, dst_addr and length; clear the index and words_done.
  - Next state is READ if length != 0, otherwise DONE.
  - start while not in IDLE is ignored.
- READ:
  - mem_read=1, mem_addr = src + idx (mod 2^ADDR_WIDTH).
  - Next state: WAIT.
- WAIT:
  - mem_read=0; mem_addr is held.
  - mem_rdata is captured into the data register at the end of this cycle.
  - Next state: WRITE.
- WRITE:
  - mem_write_en=1, mem_addr = dst + idx (mod 2^ADDR_WIDTH), mem_wdata = captured data.
  - At the end of the cycle, idx and words_done increment by 1.
  - Next state is DONE if idx+1 == length, otherwise READ.
- DONE:
  - done=1 for exactly one cycle; busy is still 1.
  - Next state: IDLE (busy=0 there).
- Timing:
  - Each word costs 3 cycles (READ, WAIT, WRITE).
  - The done pulse appears 3*length + 1 cycles after the start-accept edge.
  - With length=0, done appears 1 cycle after acceptance and no memory strobe is issued.
- Strobes: mem_read and mem_write_en are never high in the same cycle. Outside READ and WRITE both are 0.
- Address arithmetic: addresses wrap modulo 2^ADDR_WIDTH; no error is flagged.
- Overlap: copies always run forward (ascending index). For overlapping ranges with dst > src, words already written are re-read; this is the specified behaviour.
- Length: the maximum is 2^ADDR_WIDTH - 1 words.
- words_done holds its final value after DONE until the next accepted start.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - Extra output checksum (32 bits), reset to 0 and cleared on accepted start.
  - In each WRITE cycle, checksum += captured data (mod 2^32).
  - The value is final and stable when done pulses.
- Undefined: no checksum port and no accumulator logic. All other behaviour is identical.

Test Plan:
- Reset then idle: assert rst for 2 cycles, release -> all outputs 0; no strobes for 20 cycles with start=0.
- Basic copy: preload mem[0x010..0x013] = 0x11111111, 0x22222222, 0x33333333, 0x44444444; start with src=0x010, dst=0x100, length=4 -> mem[0x100..0x103] match the source; done pulses 13 cycles after acceptance; words_done = 4.
- Zero length: start with length=0 -> done pulses 1 cycle after acceptance; mem_read and mem_write_en stay 0 throughout.
- Wrap-around: src=0x3FE, dst=0x001, length=3 -> reads at 0x3FE, 0x3FF, 0x000; writes at 0x001, 0x002, 0x003 with the matching data.
- Start while busy and reset mid-transfer:
  - Pulse start during the 2nd word of a length-4 copy -> ignored; the transfer completes unchanged.
  - Assert rst during a WRITE cycle -> mem_write_en drops immediately (asynchronously); state returns to IDLE; no done pulse.
- Checksum (with MEM_COPY_CHECKSUM_EN): copy 0xFFFFFFFF and 0x00000002 -> checksum = 0x00000001 at done.
